// File: rtl/alu_op_issuer_if.sv
// Request/response handshake bundle between
// execute control and the ALU operation issuer.
interface alu_op_issuer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_x;
  logic [7:0] resp_flags;
  logic       resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output resp_ready,
    input  req_ready,
    input  resp_valid, resp_x, resp_flags, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  resp_ready,
    output req_ready,
    output resp_valid, resp_x, resp_flags, resp_err
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues one op to the 8-bit ALU, waits out its
// latency and returns X/Flags; rejects bad ops.
module alu_op_issuer #(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_issuer_if.slave   s,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [7:0]       alu_sel,
  input  logic [7:0]       alu_x,
  input  logic [7:0]       alu_flags,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [7:0]       r_alu_sel;
  logic [7:0]       r_resp_x;
  logic [7:0]       r_resp_flags;
  logic             r_resp_err;
  logic             r_resp_valid;
  logic [CNT_W-1:0] r_ops_done;

  logic w_div_op;
  logic w_illegal;

  // Opcode zero, out of range, or div/mod by zero
  assign w_div_op  = (s.req_op == 8'd4) ||
                     (s.req_op == 8'd5);
  assign w_illegal = (s.req_op == 8'd0) ||
                     (s.req_op > 8'd8) ||
                     (w_div_op && (s.req_b == 8'd0));

  assign s.req_ready    = (r_state == S_IDLE);
  assign s.resp_valid   = r_resp_valid;
  assign s.resp_x       = r_resp_x;
  assign s.resp_flags   = r_resp_flags;
  assign s.resp_err     = r_resp_err;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_sel        = r_alu_sel;
  assign ops_done       = r_ops_done;

  // Issue / wait / respond sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_resp_x     <= '0;
      r_resp_flags <= '0;
      r_resp_err   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (s.req_valid) begin
            if (w_illegal) begin
              r_resp_err   <= 1'b1;
              r_resp_x     <= '0;
              r_resp_flags <= '0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_alu_a   <= s.req_a;
              r_alu_b   <= s.req_b;
              r_alu_sel <= s.req_op;
              r_cnt     <= 4'(ALU_LATENCY);
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_resp_x     <= alu_x;
            r_resp_flags <= alu_flags;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_alu_sel    <= '0;
            r_ops_done   <= r_ops_done + 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (s.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
